dac_buf_playback: RTL

DAC_BUF_PLAYBACK -- requirements
Module: dac_buf_playback

---
 rtl/dac_buf_playback.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dac_buf_playback.sv
// Buffer-to-DAC playback engine: streams ADDR_W-addressed samples from a 1-cycle-latency
// buffer into a registered 14-bit offset-binary DAC code, with one-shot or looped playback.
module dac_buf_playback #(
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 12,
  parameter logic [13:0] MIDSCALE = 14'h2000
) (
  input  logic              dac_clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_en_i,
  input  logic [ADDR_W:0]   play_len_i,
  output logic              dac_buf_rd_o,
  output logic [ADDR_W-1:0] dac_buf_addr_o,
  input  logic [DATA_W-1:0] dac_buf_data_i,
  output logic [13:0]       dac_ch1_data_o,
  output logic              dac_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        loop_cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              loop_q, loop_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              drain_q, drain_d;
  logic              done_q, done_d;
  logic [1:0]        vld_pipe_q;
  logic [13:0]       data_q;
  logic              last;
  logic              flush;

  // len_q is one bit wider than the address so a full-buffer length is representable
  assign last  = ({1'b0, addr_q} == (len_q - (ADDR_W+1)'(1)));
  assign flush = stop_i && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    len_d   = len_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    drain_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start_i && !stop_i && (play_len_i != '0)) begin
          state_d = RUN;
          rd_d    = 1'b1;
          len_d   = play_len_i;
          loop_d  = loop_en_i;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
          addr_d  = '0;
        end else if (last) begin
          if (loop_q) begin
            addr_d = '0;
            rd_d   = 1'b1;
            cnt_d  = cnt_q + 8'd1;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          rd_d   = 1'b1;
        end
      end
      DRAIN: begin
        if (stop_i) begin
          state_d = IDLE;
          addr_d  = '0;
        end else if (drain_q) begin
          state_d = IDLE;
          addr_d  = '0;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dac_clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  // vld_pipe_q[0] marks buffer data arriving this cycle; an abort drops anything in flight
  always_ff @(posedge dac_clk_i) begin
    if (!rst_n_i || flush) begin
      vld_pipe_q <= '0;
      data_q     <= MIDSCALE;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], rd_q};
      data_q     <= vld_pipe_q[0] ? (14'(dac_buf_data_i) << (14 - DATA_W)) : MIDSCALE;
    end
  end

  assign dac_buf_rd_o   = rd_q;
  assign dac_buf_addr_o = addr_q;
  assign dac_ch1_data_o = data_q;
  assign dac_valid_o    = vld_pipe_q[1];
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign loop_cnt_o     = cnt_q;

endmodule
